// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between EX/MEM and MEM/WB.
// Runs a two-state request/ack handshake with a bounded wait and a sticky error flag.
module mem_access_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write_enable_in,
   input  logic        mem_write_enable_in,
   input  logic        mem_read_enable_in,
   input  logic        byte_access_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   input  logic [31:0] alu_result_in,
   input  logic [3:0]  rd_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        dmem_size,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        reg_write_enable_out,
   output logic [31:0] wb_data_out,
   output logic [3:0]  rd_out,
   output logic        mem_error
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state, next_state;
   logic [7:0]  cnt;
   logic        lat_rw;
   logic [31:0] lat_alu;
   logic [3:0]  lat_rd;
   logic        access, aligned, accept, busy, timeout_hit;
   logic [7:0]  lane;
   assign busy        = (state == BUSY);
   assign access      = mem_write_enable_in | mem_read_enable_in;
   assign aligned     = byte_access_in | (addr_in[1:0] == 2'b00);
   assign accept      = ~busy & access & aligned;
   assign timeout_hit = busy & (cnt == 8'(TIMEOUT - 1)) & ~dmem_ack;
   assign stall       = accept | (busy & ~dmem_ack & ~timeout_hit);
   assign dmem_req    = busy;
   assign lane        = 8'(dmem_rdata >> {dmem_addr[1:0], 3'b000});
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= next_state;
   always_comb begin
      next_state = state;
      next_state = busy ? ((dmem_ack | timeout_hit) ? IDLE : BUSY) : (accept ? BUSY : IDLE);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt                  <= '0;
         dmem_we              <= 1'b0;
         dmem_addr            <= '0;
         dmem_wdata           <= '0;
         dmem_size            <= 1'b0;
         lat_rw               <= 1'b0;
         lat_alu              <= '0;
         lat_rd               <= '0;
         reg_write_enable_out <= 1'b0;
         wb_data_out          <= '0;
         rd_out               <= '0;
         mem_error            <= 1'b0;
      end else if (!busy) begin
         if (accept) begin
            cnt                  <= '0;
            dmem_we              <= mem_write_enable_in;
            dmem_addr            <= addr_in;
            dmem_wdata           <= byte_access_in ? {4{store_data_in[7:0]}} : store_data_in;
            dmem_size            <= byte_access_in;
            lat_rw               <= reg_write_enable_in;
            lat_alu              <= alu_result_in;
            lat_rd               <= rd_in;
            reg_write_enable_out <= 1'b0;
         end else if (access) begin
            mem_error            <= 1'b1;
            reg_write_enable_out <= 1'b0;
         end else begin
            reg_write_enable_out <= reg_write_enable_in;
            wb_data_out          <= alu_result_in;
            rd_out               <= rd_in;
         end
      end else if (dmem_ack) begin
         reg_write_enable_out <= lat_rw;
         rd_out               <= lat_rd;
         wb_data_out          <= dmem_we ? lat_alu : (dmem_size ? {24'b0, lane} : dmem_rdata);
      end else begin
         // Timeout drops back to IDLE via next_state; the counter value is then don't-care.
         cnt                  <= cnt + 8'd1;
         reg_write_enable_out <= 1'b0;
         if (timeout_hit) mem_error <= 1'b1;
      end
endmodule
